// File: rtl/if_id_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg_if
//   Bundles the fetch-to-decode signals of the IF/ID pipeline register.
//   master : the fetch/hazard side. It drives freeze, flush, PC_in and
//            Instruction_in, and observes the registered outputs.
//   slave  : the pipeline register itself.
//   Signals
//     freeze         hazard stall from decode, hold contents
//     flush          branch taken, squash the entry to a NOP bubble
//     PC_in          PC+4 from fetch
//     Instruction_in instruction word from fetch
//     PC             registered PC+4 to decode
//     Instruction    registered instruction to decode
//     valid          entry holds a real fetched instruction
//     flush_count    saturating count of flushed cycles
//     stall_count    saturating count of cycles a valid entry was frozen
// ---------------------------------------------------------------------------
interface if_id_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              freeze;
    logic              flush;
    logic [DATA_W-1:0] PC_in;
    logic [DATA_W-1:0] Instruction_in;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] Instruction;
    logic              valid;
    logic [CNT_W-1:0]  flush_count;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output freeze, flush, PC_in, Instruction_in,
        input  PC, Instruction, valid, flush_count, stall_count
    );

    modport slave (
        input  freeze, flush, PC_in, Instruction_in,
        output PC, Instruction, valid, flush_count, stall_count
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//   Pipeline register between instruction fetch and instruction decode.
//   It captures PC+4 and the instruction word every cycle and holds them while
//   decode signals a hazard freeze. When a branch is taken it squashes them to
//   a NOP bubble. A valid bit follows the entry. Two saturating counters
//   (flushes, and stalls of a valid entry) are kept for performance debug.
//   Ports
//     clk  : pipeline clock, all state changes on the rising edge
//     rst  : synchronous active-high reset
//     bus  : slave side of if_id_pipe_reg_if
//            (freeze/flush/PC_in/Instruction_in in; PC/Instruction/valid/
//            flush_count/stall_count out)
//   Every output comes straight from a flop. No combinational path runs from
//   an input to an output. Priority on each edge is rst > flush > freeze > load.
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int          DATA_W    = 32,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    if_id_pipe_reg_if.slave  bus
);

    logic [DATA_W-1:0] pc_p1;
    logic [DATA_W-1:0] instr_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  flush_cnt_p1;
    logic [CNT_W-1:0]  stall_cnt_p1;

    // Increment that sticks at all-ones, so a long run never wraps back to
    // a small value and misleads whoever reads the counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    // ---- IF -> ID stage boundary: entry (PC, instruction, valid) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p1    <= '0;
            instr_p1 <= DATA_W'(NOP_INSTR);
            vld_p1   <= 1'b0;
        end else if (bus.flush) begin
            // The wrong-path instruction must die even if decode is stalling.
            pc_p1    <= '0;
            instr_p1 <= DATA_W'(NOP_INSTR);
            vld_p1   <= 1'b0;
        end else if (!bus.freeze) begin
            pc_p1    <= bus.PC_in;
            instr_p1 <= bus.Instruction_in;
            vld_p1   <= 1'b1;
        end
    end

    // ---- performance counters, updated on the same edge as the entry ----
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_p1 <= '0;
            stall_cnt_p1 <= '0;
        end else if (bus.flush) begin
            flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end else if (bus.freeze && vld_p1) begin
            // A frozen bubble holds no real work, so it is not counted.
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign bus.PC          = pc_p1;
    assign bus.Instruction = instr_p1;
    assign bus.valid       = vld_p1;
    assign bus.flush_count = flush_cnt_p1;
    assign bus.stall_count = stall_cnt_p1;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_pipe_reg
//   Directed bench for if_id_pipe_reg. One instance uses 16-bit counters for
//   the functional scenarios. A second instance uses 2-bit counters to reach
//   saturation. Inputs change 1 ns after the rising edge, and outputs are
//   checked at that same point.
// ---------------------------------------------------------------------------
module tb_if_id_pipe_reg;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    if_id_pipe_reg_if #(.DATA_W(32), .CNT_W(16)) bus ();
    if_id_pipe_reg_if #(.DATA_W(32), .CNT_W(2))  bus2 ();

    if_id_pipe_reg #(.DATA_W(32), .CNT_W(16), .NOP_INSTR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    if_id_pipe_reg #(.DATA_W(32), .CNT_W(2), .NOP_INSTR(32'h0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.freeze = 1'b0; bus.flush = 1'b0;
        bus.PC_in = 32'h1234_5678; bus.Instruction_in = 32'hDEAD_BEEF;
        bus2.freeze = 1'b0; bus2.flush = 1'b0;
        bus2.PC_in = 32'h0; bus2.Instruction_in = 32'h0;
        tick(); tick();
        tests++; if (bus.PC !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h want %h", bus.PC, 32'h0); end
        tests++; if (bus.Instruction !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h want %h", bus.Instruction, 32'h0); end
        tests++; if (bus.valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        tests++; if (bus.flush_count !== 16'd0) begin failed++; $display("FAIL reset_flush_cnt: got %0d want 0", bus.flush_count); end
        tests++; if (bus.stall_count !== 16'd0) begin failed++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_load();
        rst = 1'b0;
        bus.PC_in = 32'd4; bus.Instruction_in = 32'h2001_000A;
        tick();
        tests++; if (bus.PC !== 32'd4) begin failed++; $display("FAIL load_pc: got %h want %h", bus.PC, 32'd4); end
        tests++; if (bus.Instruction !== 32'h2001_000A) begin failed++; $display("FAIL load_instr: got %h want %h", bus.Instruction, 32'h2001_000A); end
        tests++; if (bus.valid !== 1'b1) begin failed++; $display("FAIL load_valid: got %b want 1", bus.valid); end
        tests++; if (bus.flush_count !== 16'd0) begin failed++; $display("FAIL load_flush_cnt: got %0d want 0", bus.flush_count); end
        tests++; if (bus.stall_count !== 16'd0) begin failed++; $display("FAIL load_stall_cnt: got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_freeze();
        logic [31:0] pcs [3] = '{32'd12, 32'd16, 32'd20};
        bus.PC_in = 32'd8; bus.Instruction_in = 32'h8C22_0004;
        tick();
        tests++; if (bus.PC !== 32'd8) begin failed++; $display("FAIL freeze_preload_pc: got %h want %h", bus.PC, 32'd8); end
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.PC_in = pcs[i]; bus.Instruction_in = 32'hFFFF_0000 | pcs[i];
            tick();
            tests++; if (bus.PC !== 32'd8) begin failed++; $display("FAIL freeze_hold_pc[%0d]: got %h want %h", i, bus.PC, 32'd8); end
            tests++; if (bus.Instruction !== 32'h8C22_0004) begin failed++; $display("FAIL freeze_hold_instr[%0d]: got %h want %h", i, bus.Instruction, 32'h8C22_0004); end
            tests++; if (bus.stall_count !== 16'(i + 1)) begin failed++; $display("FAIL freeze_stall_cnt[%0d]: got %0d want %0d", i, bus.stall_count, i + 1); end
        end
        tests++; if (bus.valid !== 1'b1) begin failed++; $display("FAIL freeze_valid: got %b want 1", bus.valid); end
    endtask

    task automatic test_flush_over_freeze();
        bus.freeze = 1'b1; bus.flush = 1'b1;
        tick();
        tests++; if (bus.PC !== 32'h0) begin failed++; $display("FAIL flushfrz_pc: got %h want %h", bus.PC, 32'h0); end
        tests++; if (bus.Instruction !== 32'h0) begin failed++; $display("FAIL flushfrz_instr: got %h want %h", bus.Instruction, 32'h0); end
        tests++; if (bus.valid !== 1'b0) begin failed++; $display("FAIL flushfrz_valid: got %b want 0", bus.valid); end
        tests++; if (bus.flush_count !== 16'd1) begin failed++; $display("FAIL flushfrz_flush_cnt: got %0d want 1", bus.flush_count); end
        tests++; if (bus.stall_count !== 16'd3) begin failed++; $display("FAIL flushfrz_stall_cnt: got %0d want 3", bus.stall_count); end
    endtask

    task automatic test_frozen_bubble();
        bus.flush = 1'b0; bus.freeze = 1'b1;
        bus.PC_in = 'x; bus.Instruction_in = 'x;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (bus.PC !== 32'h0) begin failed++; $display("FAIL bubble_pc[%0d]: got %h want %h", i, bus.PC, 32'h0); end
            tests++; if (bus.Instruction !== 32'h0) begin failed++; $display("FAIL bubble_instr[%0d]: got %h want %h", i, bus.Instruction, 32'h0); end
            tests++; if (bus.valid !== 1'b0) begin failed++; $display("FAIL bubble_valid[%0d]: got %b want 0", i, bus.valid); end
            tests++; if (bus.stall_count !== 16'd3) begin failed++; $display("FAIL bubble_stall_cnt[%0d]: got %0d want 3", i, bus.stall_count); end
        end
        bus.freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcv [4] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
        logic [31:0] iv  [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAC43_0008, 32'h1000_FFFE};
        for (int i = 0; i < 4; i++) begin
            bus.PC_in = pcv[i]; bus.Instruction_in = iv[i];
            tick();
            tests++; if (bus.PC !== pcv[i]) begin failed++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, bus.PC, pcv[i]); end
            tests++; if (bus.Instruction !== iv[i]) begin failed++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, bus.Instruction, iv[i]); end
            tests++; if (bus.valid !== 1'b1) begin failed++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.valid); end
        end
        tests++; if (bus.stall_count !== 16'd3) begin failed++; $display("FAIL b2b_stall_cnt: got %0d want 3", bus.stall_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus2.flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (bus2.flush_count !== exp[i]) begin failed++; $display("FAIL sat_flush_cnt[%0d]: got %0d want %0d", i, bus2.flush_count, exp[i]); end
        end
        bus2.flush = 1'b0;
        bus2.PC_in = 32'h40; bus2.Instruction_in = 32'h2002_0001;
        tick();
        tests++; if (bus2.valid !== 1'b1) begin failed++; $display("FAIL sat_load_valid: got %b want 1", bus2.valid); end
        bus2.freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (bus2.stall_count !== exp[i]) begin failed++; $display("FAIL sat_stall_cnt[%0d]: got %0d want %0d", i, bus2.stall_count, exp[i]); end
        end
        tests++; if (bus2.PC !== 32'h40) begin failed++; $display("FAIL sat_hold_pc: got %h want %h", bus2.PC, 32'h40); end
        bus2.freeze = 1'b0;
    endtask

    task automatic test_mid_reset();
        bus.flush = 1'b1;
        tick();
        tests++; if (bus.flush_count !== 16'd2) begin failed++; $display("FAIL midrst_pre_flush_cnt: got %0d want 2", bus.flush_count); end
        bus.flush = 1'b0;
        bus.PC_in = 32'h200; bus.Instruction_in = 32'h0800_0010;
        tick();
        tests++; if (bus.valid !== 1'b1) begin failed++; $display("FAIL midrst_pre_valid: got %b want 1", bus.valid); end
        // Reset wins over a simultaneous flush: the counter clears instead of stepping.
        rst = 1'b1; bus.flush = 1'b1;
        tick();
        tests++; if (bus.PC !== 32'h0) begin failed++; $display("FAIL midrst_pc: got %h want %h", bus.PC, 32'h0); end
        tests++; if (bus.Instruction !== 32'h0) begin failed++; $display("FAIL midrst_instr: got %h want %h", bus.Instruction, 32'h0); end
        tests++; if (bus.valid !== 1'b0) begin failed++; $display("FAIL midrst_valid: got %b want 0", bus.valid); end
        tests++; if (bus.flush_count !== 16'd0) begin failed++; $display("FAIL midrst_flush_cnt: got %0d want 0", bus.flush_count); end
        tests++; if (bus.stall_count !== 16'd0) begin failed++; $display("FAIL midrst_stall_cnt: got %0d want 0", bus.stall_count); end
        rst = 1'b0; bus.flush = 1'b0;
        bus.PC_in = 32'd4; bus.Instruction_in = 32'h2001_000A;
        tick();
        tests++; if (bus.PC !== 32'd4) begin failed++; $display("FAIL resume_pc: got %h want %h", bus.PC, 32'd4); end
        tests++; if (bus.Instruction !== 32'h2001_000A) begin failed++; $display("FAIL resume_instr: got %h want %h", bus.Instruction, 32'h2001_000A); end
        tests++; if (bus.valid !== 1'b1) begin failed++; $display("FAIL resume_valid: got %b want 1", bus.valid); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_freeze();
        test_flush_over_freeze();
        test_frozen_bubble();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
